egr_dpb_dirty_ptr_buf: RTL
==========================

// Module: egr_dpb_dirty_ptr_buf
// PURPOSE
//  Dirty Pointer Broker input buffer. Accepts dirty pointers released by the Packet Fetch
//  Scheduler (PFS) and queues them in a FIFO. Drains them to the pointer-return path
//  through a valid/ready handshake. Drives the DPB->PFS stall with watermark hysteresis
//  so PFS throttles before the FIFO overflows.
// PARAMETERS
//  PTR_W   16  dirty pointer width (bits)
//  DEPTH   32  FIFO entries; power of two, >= 4
//  HI_WM   24  occupancy at/above which stall asserts; LO_WM < HI_WM <= DEPTH
//  LO_WM   16  occupancy at/below which stall deasserts
//  CNT_W   $clog2(DEPTH+1)  occupancy counter width (derived, not overridden)
// PORTS
//  cclk            in   1      core clock; single clock domain
//  rst_n           in   1      synchronous, active-low reset
//  pfs_dptr_valid  in   1      PFS presents a dirty pointer this cycle (no ready; fire-and-forget)
//  pfs_dptr        in   PTR_W  dirty pointer value
//  stall           out  1      to PFS: stop issuing dirty pointers (dpb-side stall of DPB/PFS interface)
//  rtn_valid       out  1      head entry available to pointer-return path
//  rtn_ptr         out  PTR_W  head pointer value (valid only with rtn_valid)
//  rtn_ready       in   1      pointer-return path accepts head this cycle
//  occupancy       out  CNT_W  current FIFO entry count (registered)
//  overflow_err    out  1      sticky: a pointer arrived while full and was dropped
//  err_clr         in   1      clears overflow_err
// BEHAVIOUR
//  Reset (rst_n=0 sampled at cclk edge):
//   - wr/rd pointers and occupancy go to 0; stall=0, rtn_valid=0, overflow_err=0.
//   - FIFO contents are not reset.
//   - Reset mid-operation discards all queued pointers. Outputs take reset values on the following edge.
//  Push: push = pfs_dptr_valid && (!full || pop). The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
//  Pop: pop = rtn_valid && rtn_ready. rd_ptr increments modulo DEPTH.
//  rtn_valid = (occupancy != 0). rtn_ptr = mem[rd_ptr]. The path is first-word-fall-through.
//   - Written entry is visible on rtn_* the cycle after the push (0-cycle bypass NOT provided).
//  Occupancy: occ_nxt = occupancy + push - pop. This never exceeds DEPTH and never underflows.
//   - Use a CNT_W-bit counter. wr/rd pointers are log2(DEPTH) bits and wrap naturally.
//  Full (occupancy==DEPTH) with simultaneous pop:
//   - Push is accepted; occupancy is unchanged.
//  Full without pop and pfs_dptr_valid=1:
//   - Pointer is dropped; no state change to FIFO.
//   - overflow_err sets on next edge.
//  Empty with rtn_ready=1: no pop; rtn_valid=0; pointers unchanged.
//  rtn handshake: once rtn_valid=1, rtn_ptr is held stable until popped (it is FIFO head).
//  Stall hysteresis (registered, computed from occ_nxt):
//   - occ_nxt >= HI_WM -> stall<=1.
//   - occ_nxt <= LO_WM -> stall<=0.
//   - Otherwise stall holds its value.
//   - stall therefore changes the same edge occupancy reaches the threshold.
//   - PFS has up to (DEPTH-HI_WM) cycles of in-flight headroom after stall asserts.
//  overflow_err:
//   - Set has priority over err_clr in the same cycle.
//   - Otherwise err_clr=1 clears it on the next edge.
//  No combinational path from inputs to stall or occupancy. rtn_valid/rtn_ptr are from registers/array only.
//  Elaboration assertion: LO_WM < HI_WM <= DEPTH, and DEPTH is a power of two.
// TESTING
//  T1 reset:
//   - Stimulus: drive rst_n=0 for 2 cycles mid-traffic with occupancy=10, then release.
//   - Required: occupancy=0, rtn_valid=0, stall=0, overflow_err=0; first push after release appears at rtn_ptr.
//  T2 ordering and wrap:
//   - Stimulus: push 0x0001..0x0050 (80 ptrs) with rtn_ready toggling 1/0.
//   - Required: pops return 0x0001..0x0050 in order, none lost, pointers wrap 2x.
//  T3 hysteresis:
//   - Stimulus: rtn_ready=0, push 24 ptrs. Then rtn_ready=1 with no pushes.
//   - Required: stall=1 on the edge occupancy hits 24; stays 1 through occupancy 17; deasserts on the edge occupancy hits 16.
//  T4 overflow:
//   - Stimulus: rtn_ready=0, push 33 ptrs (ignore stall).
//   - Required: occupancy=32; 33rd ptr dropped; overflow_err=1 and stays 1.
//   - Then err_clr=1 for 1 cycle -> overflow_err=0.
//  T5 full with simultaneous push+pop:
//   - Stimulus: at occupancy=32, drive pfs_dptr_valid=1 with 0xABCD and rtn_ready=1.
//   - Required: occupancy stays 32, overflow_err=0, and 0xABCD pops 32 pops later.
//  T6 empty pop:
//   - Stimulus: occupancy=0, rtn_ready=1 for 5 cycles.
//   - Required: rtn_valid=0 throughout, occupancy=0, no pointer movement.

Source files
------------

// File: rtl/egr_dpb_dirty_ptr_buf.sv
// Dirty Pointer Broker input buffer.
// Queues dirty pointers released by the Packet Fetch Scheduler in a
// first-word-fall-through FIFO. The FIFO drains to the pointer-return path
// through a valid/ready handshake. A hysteresis stall tells PFS to back off
// before the FIFO overflows. A pointer that arrives while the FIFO is full,
// with no pop in the same cycle, is dropped and latches a sticky error flag.
module egr_dpb_dirty_ptr_buf #(
  parameter  int PTR_W = 16,
  parameter  int DEPTH = 32,
  parameter  int HI_WM = 24,
  parameter  int LO_WM = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             cclk,
  input  logic             rst_n,
  // PFS side: fire-and-forget, throttled only through stall
  input  logic             pfs_dptr_valid,
  input  logic [PTR_W-1:0] pfs_dptr,
  output logic             stall,
  // pointer-return side
  output logic             rtn_valid,
  output logic [PTR_W-1:0] rtn_ptr,
  input  logic             rtn_ready,
  // status
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow_err,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);

  // Bad watermark or depth settings would silently break the stall contract,
  // so they are rejected at elaboration time.
  if (!((LO_WM < HI_WM) && (HI_WM <= DEPTH)) ||
      ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_cfg
    $error("egr_dpb_dirty_ptr_buf: need LO_WM < HI_WM <= DEPTH, DEPTH pow2 >= 4");
  end

  logic [PTR_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             stall_q, stall_d;
  logic             err_q, err_d;

  logic             full, empty;
  logic             push, pop, drop;

  // Handshake decode. When the FIFO is full, a pop frees the head slot in
  // the same edge, so a concurrent push can still be accepted.
  always_comb begin
    full  = (occ_q == CNT_W'(DEPTH));
    empty = (occ_q == '0);
    pop   = !empty && rtn_ready;
    push  = pfs_dptr_valid && (!full || pop);
    drop  = pfs_dptr_valid && full && !pop;
  end

  // Next state for the pointers, the occupancy, the stall hysteresis and the error flag.
  // The pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);

    // The stall is derived from next occupancy, so it flips on the same edge
    // that the occupancy reaches a watermark.
    stall_d = stall_q;
    if (occ_d >= CNT_W'(HI_WM)) begin
      stall_d = 1'b1;
    end else if (occ_d <= CNT_W'(LO_WM)) begin
      stall_d = 1'b0;
    end

    // A new drop wins over a clear in the same cycle, so no drop can go unreported.
    err_d = err_q;
    if (drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Control state register with synchronous reset. Reset discards queued entries.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Storage array, not reset. Writes are held off during reset so that the array
  // does not change while the pointers are being reinitialised.
  always_ff @(posedge cclk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= pfs_dptr;
    end
  end

  // The head is read straight out of the array. With no write bypass, a new entry
  // becomes visible one cycle after the push.
  assign rtn_valid    = !empty;
  assign rtn_ptr      = mem_q[rd_ptr_q];
  assign stall        = stall_q;
  assign occupancy    = occ_q;
  assign overflow_err = err_q;

endmodule
